ppi_bus_master: RTL



---
 rtl/ppi_pkg.sv | 25 ++
 rtl/ppi_bus_master_if.sv | 27 ++
 rtl/ppi_phase_timer.sv | 30 +++
 rtl/ppi_bus_master.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/ppi_pkg.sv
// Shared types and constants for the PPI bus master and its phase timer.
package ppi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } ppi_bus_state_t;

  localparam logic [1:0] PPI_ADDR_A    = 2'd0;
  localparam logic [1:0] PPI_ADDR_B    = 2'd1;
  localparam logic [1:0] PPI_ADDR_C    = 2'd2;
  localparam logic [1:0] PPI_ADDR_CTRL = 2'd3;

  localparam logic [7:0] PPI_CTRL_RESET = 8'h9B;
  localparam logic [7:0] PPI_ILLEGAL_RD = 8'hFF;

  function automatic int ppi_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ppi_bus_master_if.sv
// Request/response handshake plus PPI pin bundle; the master modport is the bus master's view.
interface ppi_bus_master_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [1:0] req_addr;
  logic [7:0] req_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic [1:0] A;
  logic       READ;
  logic       WRITE;
  logic [7:0] DATA_out;
  logic       DATA_oe;
  logic [7:0] DATA_in;

  modport master (
    input  req_valid, req_write, req_addr, req_data, DATA_in,
    output req_ready, rsp_valid, rsp_data, busy, A, READ, WRITE, DATA_out, DATA_oe
  );

  modport slave (
    output req_valid, req_write, req_addr, req_data, DATA_in,
    input  req_ready, rsp_valid, rsp_data, busy, A, READ, WRITE, DATA_out, DATA_oe
  );
endinterface

// File: rtl/ppi_phase_timer.sv
// Loadable down-counter shared by the SETUP/STROBE/HOLD phases; done while the count is zero.
module ppi_phase_timer #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic          done_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturates at zero so an idle timer never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/ppi_bus_master.sv
// Runs one timed PPI bus cycle (SETUP/STROBE/HOLD) per accepted request; all outputs registered.
// Optional PPI_MASTER_SHADOW_EN adds ctrl_shadow, a copy of the last control-word write.
module ppi_bus_master
  import ppi_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  ppi_bus_master_if.master bus
`ifdef PPI_MASTER_SHADOW_EN
  ,
  output logic [7:0]       ctrl_shadow
`endif
);

  // state  | meaning
  // IDLE   | ready for a request, A holds last address
  // SETUP  | address/data driven ahead of the strobe
  // STROBE | READ or WRITE high, read data captured on the last edge
  // HOLD   | strobe low, address/data still driven

  localparam int CW = $clog2(ppi_max3(SETUP_CYC, STROBE_CYC, HOLD_CYC)) + 1;
  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC - 1);

  ppi_bus_state_t state_q, state_d;

  logic          tmr_load;
  logic [CW-1:0] tmr_ld_val;
  logic          tmr_done;

  logic       wr_q, wr_d;
  logic [1:0] a_q, a_d;
  logic [7:0] dout_q, dout_d;
  logic       oe_q, oe_d;
  logic       rd_q, rd_d;
  logic       wrs_q, wrs_d;
  logic       rsp_v_q, rsp_v_d;
  logic [7:0] rsp_dat_q, rsp_dat_d;
  logic       busy_q, busy_d;
  logic       ready_q, ready_d;

  logic accept;
  logic strobe_end;

  assign accept     = bus.req_valid & ready_q;
  assign strobe_end = (state_q == STROBE) & tmr_done;

  ppi_phase_timer #(.CW(CW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_ld_val),
    .done_o     (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_q      <= 1'b0;
      a_q       <= 2'b00;
      dout_q    <= 8'h00;
      oe_q      <= 1'b0;
      rd_q      <= 1'b0;
      wrs_q     <= 1'b0;
      rsp_v_q   <= 1'b0;
      rsp_dat_q <= 8'h00;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      a_q       <= a_d;
      dout_q    <= dout_d;
      oe_q      <= oe_d;
      rd_q      <= rd_d;
      wrs_q     <= wrs_d;
      rsp_v_q   <= rsp_v_d;
      rsp_dat_q <= rsp_dat_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tmr_load   = 1'b0;
    tmr_ld_val = '0;
    case (state_q)
      IDLE: if (accept) begin
        state_d    = SETUP;
        tmr_load   = 1'b1;
        tmr_ld_val = SETUP_LD;
      end
      SETUP: if (tmr_done) begin
        state_d    = STROBE;
        tmr_load   = 1'b1;
        tmr_ld_val = STROBE_LD;
      end
      STROBE: if (tmr_done) begin
        state_d    = HOLD;
        tmr_load   = 1'b1;
        tmr_ld_val = HOLD_LD;
      end
      HOLD: if (tmr_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are derived from the next state so they line up with it.
  always_comb begin
    wr_d   = wr_q;
    a_d    = a_q;
    dout_d = dout_q;
    if (accept) begin
      wr_d = bus.req_write;
      a_d  = bus.req_addr;
      if (bus.req_write) dout_d = bus.req_data;
    end
    busy_d  = (state_d != IDLE);
    ready_d = ~busy_d;
    oe_d    = busy_d & wr_d;
    wrs_d   = (state_d == STROBE) & wr_d;
    rd_d    = (state_d == STROBE) & ~wr_d & (a_d != PPI_ADDR_CTRL);
    rsp_v_d = strobe_end & ~wr_q;
    rsp_dat_d = rsp_dat_q;
    if (rsp_v_d)
      rsp_dat_d = (a_q == PPI_ADDR_CTRL) ? PPI_ILLEGAL_RD : bus.DATA_in;
  end

`ifdef PPI_MASTER_SHADOW_EN
  logic [7:0] shadow_q;

  always_ff @(posedge clk) begin
    if (rst)
      shadow_q <= PPI_CTRL_RESET;
    else if (strobe_end & wr_q & (a_q == PPI_ADDR_CTRL))
      shadow_q <= dout_q;
  end

  assign ctrl_shadow = shadow_q;
`endif

  assign bus.req_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_v_q;
  assign bus.rsp_data  = rsp_dat_q;
  assign bus.A         = a_q;
  assign bus.READ      = rd_q;
  assign bus.WRITE     = wrs_q;
  assign bus.DATA_out  = dout_q;
  assign bus.DATA_oe   = oe_q;

endmodule
